// File: rtl/tick_debounce.sv
// ---------------------------------------------------------------------------
// tick_debounce
//   Debounces a raw asynchronous level against a shared time-base strobe.
//   The raw input is synchronized, then a new level must persist for
//   STABLE_TICKS consecutive ticks before it is accepted on dout.  Ticks that
//   arrive in the same cycle as the first disagreement are not counted, so a
//   permanently-high tick still gives a deterministic latency.
//
// Ports
//   clk   in  1  rising-edge clock
//   rst   in  1  synchronous active-high reset
//   tick  in  1  one-cycle time-base strobe (any duty cycle, including 1)
//   din   in  1  raw asynchronous level
//   dout  out 1  debounced level (registered)
//   rise  out 1  one-cycle pulse on dout 0->1 (registered)
//   fall  out 1  one-cycle pulse on dout 1->0 (registered)
//   busy  out 1  a candidate level change is being qualified
// ---------------------------------------------------------------------------
module tick_debounce #(
    parameter int unsigned STABLE_TICKS = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter logic        RESET_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int unsigned     CW   = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0]   LAST = CW'(STABLE_TICKS - 1);

    // Parameter range checks, reported at elaboration.
    if (STABLE_TICKS < 1 || STABLE_TICKS > 65535) begin : g_bad_stable_ticks
        $error("tick_debounce: STABLE_TICKS out of range 1..65535");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("tick_debounce: SYNC_STAGES out of range 2..4");
    end

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_QUALIFY = 1'b1
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   dout_q, dout_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    logic s;
    logic differ;
    logic commit;

    assign s      = sync_q[SYNC_STAGES-1];
    assign differ = (s != dout_q);
    // Last qualifying tick: the candidate level is accepted on this edge.
    assign commit = (state_q == ST_QUALIFY) && differ && tick && (cnt_q == LAST);

    // State register (plus synchronizer and registered outputs)
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            dout_q  <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_STABLE: begin
                // The tick in the entry cycle is deliberately not counted.
                cnt_d = '0;
                if (differ) state_d = ST_QUALIFY;
            end
            ST_QUALIFY: begin
                if (!differ) begin
                    // Glitch: input fell back before qualifying; wins over tick.
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == LAST) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        dout_d = dout_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (commit) begin
            dout_d = s;
            rise_d = s;
            fall_d = ~s;
        end
    end

    assign busy = (state_q == ST_QUALIFY);
    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule
